// File: rtl/mem_bus_responder_pkg.sv
// Shared address map and TXSTAT layout for the memory-bus responder.
package mem_bus_responder_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned ByteW = 8;

    localparam logic [DataW-1:0] DmemBase   = 32'h0000_0800;
    localparam logic [DataW-1:0] LedAddr    = 32'h0000_0C00;
    localparam logic [DataW-1:0] DipAddr    = 32'h0000_0C04;
    localparam logic [DataW-1:0] TimerAddr  = 32'h0000_0C08;
    localparam logic [DataW-1:0] TxDataAddr = 32'h0000_0C0C;
    localparam logic [DataW-1:0] TxStatAddr = 32'h0000_0C10;

    localparam int unsigned TxStatCountW   = 4;
    localparam int unsigned TxStatEmptyBit = 4;
    localparam int unsigned TxStatFullBit  = 5;
    localparam int unsigned TxStatOvfBit   = 6;

    // Word-granular match; the byte-lane bits never take part in decode.
    function automatic logic regHit(input logic [DataW-1:0] addr, input logic [DataW-1:0] reg_addr);
        return addr[DataW-1:2] == reg_addr[DataW-1:2];
    endfunction

endpackage

// File: rtl/mem_bus_responder_tx_fifo.sv
// Byte FIFO feeding the transmit sink; head byte reads as zero when empty.
module tx_fifo
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ByteW-1:0]        wrData,
    output logic [ByteW-1:0]        headData,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic [ByteW-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rdPtr;
    logic [PtrW-1:0]  wrPtr;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CountW'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = empty ? '0 : mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            count <= count + CountW'(doPush) - CountW'(doPop);
        end
    end

    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Data-memory and peripheral responder for the core's M stage: DMEM, LED,
// synchronized DIP switches, free-running timer and a byte TX FIFO.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 128,
    parameter int unsigned TXF_DEPTH  = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] OpResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [15:0] DIP,
    output logic [7:0]  LED,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned DmemIdxW = $clog2(DMEM_WORDS);
    localparam int unsigned TxCountW = $clog2(TXF_DEPTH) + 1;

    logic [29:0]          wordAddr;
    logic [29:0]          dmemOff;
    logic [DmemIdxW-1:0]  dmemIdx;
    logic                 dmemHit;
    logic                 ledHit;
    logic                 dipHit;
    logic                 timerHit;
    logic                 txDataHit;
    logic                 txStatHit;
    logic                 unusedByteLane;

    logic [DataW-1:0]     dmem [DMEM_WORDS];
    logic [15:0]          dipMeta;
    logic [15:0]          dipSync;
    logic [DataW-1:0]     timer;

    logic                 txPush;
    logic                 txPop;
    logic                 txFull;
    logic                 txEmpty;
    logic                 txOverflow;
    logic                 ovfSet;
    logic                 ovfClr;
    logic [TxCountW-1:0]  txCount;
    logic [DataW-1:0]     txStat;

    // Address decode over the full word address.
    assign wordAddr       = OpResult[31:2];
    assign unusedByteLane = ^OpResult[1:0];
    assign dmemOff        = wordAddr - DmemBase[31:2];
    assign dmemHit        = (wordAddr >= DmemBase[31:2]) && (dmemOff < 30'(DMEM_WORDS));
    assign dmemIdx        = dmemOff[DmemIdxW-1:0];
    assign ledHit         = regHit(OpResult, LedAddr);
    assign dipHit         = regHit(OpResult, DipAddr);
    assign timerHit       = regHit(OpResult, TimerAddr);
    assign txDataHit      = regHit(OpResult, TxDataAddr);
    assign txStatHit      = regHit(OpResult, TxStatAddr);

    assign txPush   = MemWrite && txDataHit;
    assign tx_valid = !txEmpty;
    assign txPop    = tx_valid && tx_ready;
    assign ovfSet   = txPush && txFull;
    assign ovfClr   = MemWrite && txStatHit && WriteData[TxStatOvfBit];

    // DMEM is deliberately outside reset so contents survive it.
    always_ff @(posedge CLK) begin
        if (MemWrite && dmemHit) begin
            dmem[dmemIdx] <= WriteData;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            LED   <= '0;
            timer <= '0;
        end else begin
            if (MemWrite && ledHit) begin
                LED <= WriteData[ByteW-1:0];
            end
            timer <= (MemWrite && timerHit) ? WriteData : timer + 32'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            dipMeta <= '0;
            dipSync <= '0;
        end else begin
            dipMeta <= DIP;
            dipSync <= dipMeta;
        end
    end

    // Sticky overflow; a same-cycle set beats a software clear.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            txOverflow <= 1'b0;
        end else if (ovfSet) begin
            txOverflow <= 1'b1;
        end else if (ovfClr) begin
            txOverflow <= 1'b0;
        end
    end

    tx_fifo #(
        .DEPTH(TXF_DEPTH)
    ) uTxFifo (
        .CLK      (CLK),
        .Reset    (Reset),
        .push     (txPush),
        .pop      (txPop),
        .wrData   (WriteData[ByteW-1:0]),
        .headData (tx_data),
        .count    (txCount),
        .full     (txFull),
        .empty    (txEmpty)
    );

    always_comb begin
        txStat                         = '0;
        txStat[TxStatCountW-1:0]       = TxStatCountW'(txCount);
        txStat[TxStatEmptyBit]         = txEmpty;
        txStat[TxStatFullBit]          = txFull;
        txStat[TxStatOvfBit]           = txOverflow;
    end

    // Load data mux; unmapped and write-only locations read as zero.
    always_comb begin
        ReadData = '0;
        if (ledHit) begin
            ReadData = {24'd0, LED};
        end else if (dipHit) begin
            ReadData = {16'd0, dipSync};
        end else if (timerHit) begin
            ReadData = timer;
        end else if (txStatHit) begin
            ReadData = txStat;
        end else if (dmemHit) begin
            ReadData = dmem[dmemIdx];
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed scenarios plus a
// randomized run checked every cycle against a behavioural model.
module tb_mem_bus_responder;

    localparam int unsigned Words = 128;
    localparam int unsigned Depth = 8;

    logic        CLK       = 1'b0;
    logic        Reset     = 1'b0;
    logic        MemWrite  = 1'b0;
    logic [31:0] OpResult  = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [15:0] DIP       = 16'd0;
    logic        tx_ready  = 1'b0;
    logic [31:0] ReadData;
    logic [7:0]  LED;
    logic        tx_valid;
    logic [7:0]  tx_data;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    mem_bus_responder #(
        .DMEM_WORDS(Words),
        .TXF_DEPTH (Depth)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .MemWrite (MemWrite),
        .OpResult (OpResult),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .DIP      (DIP),
        .LED      (LED),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    // Behavioural model state
    logic [31:0] mDmem  [Words];
    bit          mKnown [Words];
    logic [7:0]  mLed   = 8'd0;
    logic [31:0] mTimer = 32'd0;
    logic [7:0]  mQ[$];
    bit          mOvf   = 1'b0;
    logic [15:0] mDip1  = 16'd0;
    logic [15:0] mDip2  = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dmemIndex(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        if (b >= 32'h800 && b < 32'h800 + 4 * Words) return int'((b - 32'h800) >> 2);
        return -1;
    endfunction

    function automatic logic [31:0] mRead(input logic [31:0] a, output bit known);
        logic [31:0] b;
        int          idx;
        int          n;
        b     = {a[31:2], 2'b00};
        idx   = dmemIndex(a);
        n     = mQ.size();
        known = 1'b1;
        if (idx >= 0) begin
            known = mKnown[idx];
            return mDmem[idx];
        end
        case (b)
            32'hC00: return {24'd0, mLed};
            32'hC04: return {16'd0, mDip2};
            32'hC08: return mTimer;
            32'hC10: return 32'(n) + (n == 0 ? 32'd16 : 32'd0) + (n == Depth ? 32'd32 : 32'd0)
                            + (mOvf ? 32'd64 : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    // Model update at each rising edge, async clear on reset.
    always @(posedge CLK or negedge Reset) begin
        logic [31:0] b;
        bit          wasFull;
        bit          pushNow;
        int          idx;
        if (!Reset) begin
            mLed   = 8'd0;
            mTimer = 32'd0;
            mQ.delete();
            mOvf   = 1'b0;
            mDip1  = 16'd0;
            mDip2  = 16'd0;
        end else begin
            b       = {OpResult[31:2], 2'b00};
            wasFull = (mQ.size() == Depth);
            pushNow = MemWrite && (b == 32'hC0C);
            if (mQ.size() != 0 && tx_ready) void'(mQ.pop_front());
            if (pushNow) begin
                if (wasFull) mOvf = 1'b1;
                else mQ.push_back(WriteData[7:0]);
            end
            if (MemWrite && b == 32'hC10 && WriteData[6] && !(pushNow && wasFull)) mOvf = 1'b0;
            mTimer = (MemWrite && b == 32'hC08) ? WriteData : mTimer + 32'd1;
            if (MemWrite && b == 32'hC00) mLed = WriteData[7:0];
            idx = dmemIndex(OpResult);
            if (MemWrite && idx >= 0) begin
                mDmem[idx]  = WriteData;
                mKnown[idx] = 1'b1;
            end
            mDip2 = mDip1;
            mDip1 = DIP;
        end
    end

    // Compare process: outputs against the model every cycle.
    always @(negedge CLK) begin
        bit          kn;
        logic [31:0] e;
        e = mRead(OpResult, kn);
        if (kn) check("model_rdata", ReadData, e);
        check("model_led", 32'(LED), 32'(mLed));
        check("model_txvalid", 32'(tx_valid), 32'(mQ.size() != 0));
        if (mQ.size() != 0) check("model_txdata", 32'(tx_data), 32'(mQ[0]));
    end

    task automatic idle();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = we;
        OpResult  = a;
        WriteData = d;
        idle();
        MemWrite  = 1'b0;
    endtask

    task automatic expectRd(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWrite = 1'b0;
        OpResult = a;
        #1;
        check(name, ReadData, exp);
    endtask

    initial begin
        int          sel;
        int          k;
        int          idx;
        logic [31:0] a;

        for (int i = 0; i < int'(Words); i++) mKnown[i] = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_led", 32'(LED), 32'd0);
        check("rst_txvalid", 32'(tx_valid), 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
        Reset = 1'b1;
        expectRd("rst_timer", 32'hC08, 32'd0);
        idle();
        expectRd("timer_first_tick", 32'hC08, 32'd1);

        // DMEM write/read, neighbour untouched, byte lanes ignored
        step(1'b1, 32'h808, 32'h1234_5678);
        step(1'b1, 32'h804, 32'hDEAD_BEEF);
        expectRd("dmem_804", 32'h804, 32'hDEAD_BEEF);
        expectRd("dmem_808", 32'h808, 32'h1234_5678);
        expectRd("dmem_806", 32'h806, 32'hDEAD_BEEF);

        // LED
        step(1'b1, 32'hC00, 32'h0000_01A5);
        check("led_value", 32'(LED), 32'hA5);
        expectRd("led_read", 32'hC00, 32'h0000_00A5);

        // Timer load and wrap
        step(1'b1, 32'hC08, 32'hFFFF_FFFE);
        expectRd("timer_load", 32'hC08, 32'hFFFF_FFFE);
        idle();
        expectRd("timer_ffff", 32'hC08, 32'hFFFF_FFFF);
        idle();
        expectRd("timer_wrap", 32'hC08, 32'h0000_0000);
        idle();
        expectRd("timer_one", 32'hC08, 32'h0000_0001);

        // DIP synchronizer latency, unmapped reads
        DIP = 16'h1234;
        expectRd("dip_edge0", 32'hC04, 32'd0);
        idle();
        expectRd("dip_edge1", 32'hC04, 32'd0);
        idle();
        expectRd("dip_edge2", 32'hC04, 32'h0000_1234);
        expectRd("unmapped_c14", 32'hC14, 32'd0);
        expectRd("alias_c04", 32'h1000_0C04, 32'd0);

        // Overfill with sink stalled, then drain in order
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) step(1'b1, 32'hC0C, 32'(i));
        expectRd("stat_full_ovf", 32'hC10, 32'h68);
        expectRd("txdata_reads0", 32'hC0C, 32'd0);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", 32'(tx_valid), 32'd1);
            check("drain_byte", 32'(tx_data), 32'(i));
            idle();
        end
        tx_ready = 1'b0;
        check("drain_empty", 32'(tx_valid), 32'd0);
        expectRd("stat_empty_ovf", 32'hC10, 32'h50);
        step(1'b1, 32'hC10, 32'h40);
        expectRd("stat_ovf_clr", 32'hC10, 32'h10);

        // Full FIFO with coincident push and pop
        for (int i = 0; i < 8; i++) step(1'b1, 32'hC0C, 32'h10 + 32'(i));
        expectRd("stat_full", 32'hC10, 32'h28);
        tx_ready = 1'b1;
        step(1'b1, 32'hC0C, 32'hAA);
        tx_ready = 1'b0;
        expectRd("stat_push_pop_full", 32'hC10, 32'h47);
        tx_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            check("pp_byte", 32'(tx_data), 32'h10 + 32'(i));
            idle();
        end
        check("pp_no_aa", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
        step(1'b1, 32'hC10, 32'h40);

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0C, 32'h31 + 32'(i));
        tx_ready = 1'b1;
        idle();
        check("mid_valid", 32'(tx_valid), 32'd1);
        check("mid_byte", 32'(tx_data), 32'h32);
        Reset = 1'b0;
        #1;
        check("arst_txvalid", 32'(tx_valid), 32'd0);
        check("arst_led", 32'(LED), 32'd0);
        tx_ready = 1'b0;
        idle();
        Reset = 1'b1;
        expectRd("rel_timer", 32'hC08, 32'd0);
        expectRd("rel_dmem", 32'h804, 32'hDEAD_BEEF);
        check("rel_txvalid", 32'(tx_valid), 32'd0);
        tx_ready = 1'b1;
        idle();
        check("rel_txvalid2", 32'(tx_valid), 32'd0);
        expectRd("rel_timer1", 32'hC08, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 11));
            case (sel)
                0, 1, 2: begin
                    k   = int'($urandom_range(0, 9));
                    idx = (k < 8) ? k : ((k == 8) ? 127 : 128);
                    a   = 32'h800 + 32'(4 * idx);
                end
                3:       a = 32'hC00;
                4:       a = 32'hC04;
                5:       a = 32'hC08;
                6, 7, 8: a = 32'hC0C;
                9:       a = 32'hC10;
                10:      a = ($urandom_range(0, 1) == 0) ? 32'hC14 : 32'h1000_0C0C;
                default: a = $urandom;
            endcase
            a         = a | 32'($urandom_range(0, 3));
            OpResult  = a;
            MemWrite  = ($urandom_range(0, 1) == 1);
            WriteData = $urandom;
            tx_ready  = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) DIP = 16'($urandom);
            Reset     = ($urandom_range(0, 499) != 0);
            idle();
        end
        Reset    = 1'b1;
        MemWrite = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
